// File: rtl/jt51_ch_wr_sched_if.sv
// Signal bundle for jt51_ch_wr_sched: CPU register-write side in, ring-facing
// data/strobes and status out.
interface jt51_ch_wr_sched_if;
   logic       wr;
   logic [7:0] addr;
   logic [7:0] din;
   logic       ovf_clr;
   logic [7:0] dout;
   logic       up_rl_ch;
   logic       up_fb_ch;
   logic       up_con_ch;
   logic       up_kc_ch;
   logic       up_kf_ch;
   logic       up_ams_ch;
   logic       up_pms_ch;
   logic [2:0] cur_ch;
   logic       busy;
   logic       full;
   logic       ovf;

   modport master (
      output wr, addr, din, ovf_clr,
      input  dout, up_rl_ch, up_fb_ch, up_con_ch, up_kc_ch, up_kf_ch,
             up_ams_ch, up_pms_ch, cur_ch, busy, full, ovf
   );

   modport slave (
      input  wr, addr, din, ovf_clr,
      output dout, up_rl_ch, up_fb_ch, up_con_ch, up_kc_ch, up_kf_ch,
             up_ams_ch, up_pms_ch, cur_ch, busy, full, ovf
   );
endinterface

// File: rtl/jt51_ch_wr_sched.sv
// Queues CPU writes to regs 0x20-0x3F and releases each one when its channel
// slot reaches the ring input. Define JT51_CHWR_COALESCE_EN to merge repeat writes.
module jt51_ch_wr_sched #(
   parameter int unsigned DEPTH     = 4,
   parameter int unsigned CH_OFFSET = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cen,
   jt51_ch_wr_sched_if.slave bus
);
   localparam int unsigned   AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned   CW       = $clog2(DEPTH + 1);
   localparam logic [2:0]    OFS      = 3'(CH_OFFSET % 8);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   typedef enum logic [1:0] {
      GRP_RFC = 2'd0,
      GRP_KC  = 2'd1,
      GRP_KF  = 2'd2,
      GRP_PA  = 2'd3
   } grp_e;

   typedef struct packed {
      grp_e       grp;
      logic [2:0] ch;
      logic [7:0] data;
   } entry_t;

   entry_t        mem [DEPTH];
   entry_t        head;
   entry_t        new_ent;
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] hit_idx;
   logic [CW-1:0] count;
   logic [CW-1:0] count_nxt;
   logic [2:0]    cnt;
   logic [2:0]    cur;
   logic          busy_r;
   logic          full_r;
   logic          ovf_r;
   logic          match;
   logic          pop;
   logic          valid;
   logic          hit;
   logic          push;
   logic          drop;

   always_comb begin
      head    = mem[rd_ptr];
      cur     = cnt + OFS;
      match   = busy_r && (head.ch == cur);
      pop     = cen && match;
      valid   = bus.wr && (bus.addr[7:5] == 3'b001);
      new_ent = '{grp: grp_e'(bus.addr[4:3]), ch: bus.addr[2:0], data: bus.din};
      hit     = 1'b0;
      hit_idx = '0;
`ifdef JT51_CHWR_COALESCE_EN
      // Head is skipped: it may be leaving this very cycle.
      for (int unsigned i = 1; i < DEPTH; i++) begin
         if (!hit && (i < 32'(count)) &&
             (mem[rd_ptr + AW'(i)].grp == new_ent.grp) &&
             (mem[rd_ptr + AW'(i)].ch  == new_ent.ch)) begin
            hit     = 1'b1;
            hit_idx = rd_ptr + AW'(i);
         end
      end
      hit = hit && valid;
`endif
      push = valid && !hit && (!full_r || pop);
      drop = valid && !hit && full_r && !pop;
      count_nxt = count;
      if (push && !pop) count_nxt = count + 1'b1;
      if (pop && !push) count_nxt = count - 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt    <= '0;
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         busy_r <= 1'b0;
         full_r <= 1'b0;
         ovf_r  <= 1'b0;
      end else begin
         if (cen)  cnt    <= cnt + 3'd1;
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         count  <= count_nxt;
         busy_r <= (count_nxt != '0);
         full_r <= (count_nxt == FULL_CNT);
         if (drop)             ovf_r <= 1'b1;
         else if (bus.ovf_clr) ovf_r <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (push)     mem[wr_ptr]         <= new_ent;
      else if (hit) mem[hit_idx].data   <= bus.din;
   end

   always_comb begin
      bus.up_rl_ch  = 1'b0;
      bus.up_fb_ch  = 1'b0;
      bus.up_con_ch = 1'b0;
      bus.up_kc_ch  = 1'b0;
      bus.up_kf_ch  = 1'b0;
      bus.up_ams_ch = 1'b0;
      bus.up_pms_ch = 1'b0;
      if (match) begin
         case (head.grp)
            GRP_RFC: begin
               bus.up_rl_ch  = 1'b1;
               bus.up_fb_ch  = 1'b1;
               bus.up_con_ch = 1'b1;
            end
            GRP_KC:  bus.up_kc_ch = 1'b1;
            GRP_KF:  bus.up_kf_ch = 1'b1;
            GRP_PA: begin
               bus.up_ams_ch = 1'b1;
               bus.up_pms_ch = 1'b1;
            end
            default: ;
         endcase
      end
      bus.dout   = busy_r ? head.data : '0;
      bus.cur_ch = cur;
      bus.busy   = busy_r;
      bus.full   = full_r;
      bus.ovf    = ovf_r;
   end
endmodule

// File: tb/tb_jt51_ch_wr_sched.sv
// Bench for jt51_ch_wr_sched: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_jt51_ch_wr_sched;
   localparam int DEPTH     = 4;
   localparam int CH_OFFSET = 0;

   logic clk;
   logic rst_n;
   logic cen;
   int   checks;
   int   errors;

   jt51_ch_wr_sched_if bus ();

   jt51_ch_wr_sched #(.DEPTH(DEPTH), .CH_OFFSET(CH_OFFSET)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .cen   (cen),
      .bus   (bus.slave)
   );

   logic [6:0] strobes;
   assign strobes = {bus.up_rl_ch, bus.up_fb_ch, bus.up_con_ch, bus.up_kc_ch,
                     bus.up_kf_ch, bus.up_ams_ch, bus.up_pms_ch};

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference model: a plain queue of pending writes plus a slot counter
   typedef struct {
      logic [1:0] g;
      logic [2:0] ch;
      logic [7:0] d;
   } ent_t;

   ent_t       mq[$];
   logic [2:0] mcnt;
   logic       movf;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      mcnt = 3'd0;
      movf = 1'b0;
   endtask

   task automatic model_step();
      logic [2:0] c;
      bit         pop;
      bit         valid;
      bit         hit;
      bit         drop;
      ent_t       e;
      if (!rst_n) return;
      c     = 3'((int'(mcnt) + CH_OFFSET) % 8);
      pop   = cen && (mq.size() != 0) && (mq[0].ch == c);
      valid = bus.wr && (bus.addr >= 8'h20) && (bus.addr <= 8'h3F);
      hit   = 1'b0;
      drop  = 1'b0;
      e.g   = bus.addr[4:3];
      e.ch  = bus.addr[2:0];
      e.d   = bus.din;
`ifdef JT51_CHWR_COALESCE_EN
      if (valid) begin
         for (int i = 1; i < mq.size(); i++) begin
            if (!hit && mq[i].g == e.g && mq[i].ch == e.ch) begin
               mq[i] = e;
               hit   = 1'b1;
            end
         end
      end
`endif
      if (pop) void'(mq.pop_front());
      if (valid && !hit) begin
         if (mq.size() < DEPTH) mq.push_back(e);
         else drop = 1'b1;
      end
      if (drop) movf = 1'b1;
      else if (bus.ovf_clr) movf = 1'b0;
      if (cen) mcnt = mcnt + 3'd1;
   endtask

   always @(negedge clk) begin
      logic [2:0] ec;
      logic [6:0] es;
      logic [7:0] ed;
      ec = 3'((int'(mcnt) + CH_OFFSET) % 8);
      es = 7'b0;
      ed = 8'h00;
      if (mq.size() != 0) begin
         ed = mq[0].d;
         if (mq[0].ch == ec) begin
            case (mq[0].g)
               2'd0: es = 7'b1110000;
               2'd1: es = 7'b0001000;
               2'd2: es = 7'b0000100;
               default: es = 7'b0000011;
            endcase
         end
      end
      check("cur_ch",  bus.cur_ch, ec);
      check("busy",    bus.busy,   mq.size() != 0);
      check("full",    bus.full,   mq.size() == DEPTH);
      check("ovf",     bus.ovf,    movf);
      check("dout",    bus.dout,   ed);
      check("strobes", strobes,    es);
   end

   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
      #1;
      bus.wr      = 1'b0;
      bus.ovf_clr = 1'b0;
   endtask

   task automatic put(input logic [7:0] a, input logic [7:0] d);
      bus.wr   = 1'b1;
      bus.addr = a;
      bus.din  = d;
      tick();
   endtask

   task automatic wait_mask(input logic [6:0] mask, input int bound, output int n);
      n = 0;
      while (((strobes & mask) == 7'b0) && n < bound) begin
         tick();
         n++;
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int         n;
      logic [7:0] got[$];
      checks      = 0;
      errors      = 0;
      rst_n       = 1'b0;
      cen         = 1'b0;
      bus.wr      = 1'b0;
      bus.addr    = 8'h00;
      bus.din     = 8'h00;
      bus.ovf_clr = 1'b0;
      model_reset();
      repeat (3) tick();
      check("rst_busy",   bus.busy,   0);
      check("rst_cur_ch", bus.cur_ch, 0);
      check("rst_dout",   bus.dout,   0);
      rst_n = 1'b1;

      // Single KC write to ch5 issued while the slot counter sits at 2
      cen = 1'b1;
      tick();
      tick();
      check("single_cnt", bus.cur_ch, 2);
      put(8'h2D, 8'h45);
      wait_mask(7'b0001000, 20, n);
      check("single_lat",  n, 2);
      check("single_ch",   bus.cur_ch, 5);
      check("single_dout", bus.dout, 8'h45);
      tick();
      check("single_idle", bus.busy, 0);

      // Reset with three entries queued
      cen = 1'b0;
      put(8'h21, 8'h11);
      put(8'h2A, 8'h22);
      put(8'h33, 8'h33);
      check("mid_busy", bus.busy, 1);
      rst_n = 1'b0;
      model_reset();
      #1;
      check("mid_rst_busy",    bus.busy,   0);
      check("mid_rst_strobes", strobes,    0);
      check("mid_rst_dout",    bus.dout,   0);
      check("mid_rst_cur",     bus.cur_ch, 0);
      check("mid_rst_ovf",     bus.ovf,    0);
      tick();
      rst_n = 1'b1;

      // RFC then PA group, both for ch0
      cen = 1'b1;
      put(8'h20, 8'hC7);
      put(8'h38, 8'h31);
      wait_mask(7'b1000000, 20, n);
      check("rfc_lat",     n, 6);
      check("rfc_strobes", strobes, 7'b1110000);
      check("rfc_dout",    bus.dout, 8'hC7);
      wait_mask(7'b0000010, 20, n);
      check("pa_gap",      n, 8);
      check("pa_strobes",  strobes, 7'b0000011);
      check("pa_dout",     bus.dout, 8'h31);
      tick();
      check("pa_idle",     bus.busy, 0);

      // Overflow while the ring is stalled
      cen = 1'b0;
      put(8'h28, 8'hA0);
      put(8'h31, 8'hA1);
      put(8'h3A, 8'hA2);
      put(8'h23, 8'hA3);
      check("ovf_full",  bus.full, 1);
      check("ovf_clear", bus.ovf,  0);
      put(8'h2C, 8'hA4);
      check("ovf_set",   bus.ovf,  1);
      bus.ovf_clr = 1'b1;
      put(8'h35, 8'hA5);
      check("ovf_setwins", bus.ovf, 1);
      bus.ovf_clr = 1'b1;
      tick();
      check("ovf_clr", bus.ovf, 0);
      cen = 1'b1;
      n = 0;
      while (bus.busy && n < 60) begin
         if (strobes != 7'b0) got.push_back(bus.dout);
         tick();
         n++;
      end
      check("drain_done", bus.busy, 0);
      check("drain_cnt",  got.size(), 4);
      if (got.size() == 4) begin
         check("drain_0", got[0], 8'hA0);
         check("drain_1", got[1], 8'hA1);
         check("drain_2", got[2], 8'hA2);
         check("drain_3", got[3], 8'hA3);
      end

      // Addresses outside the channel range are ignored
      put(8'h08, 8'h55);
      put(8'h40, 8'h66);
      put(8'h1F, 8'h77);
      check("inv_busy", bus.busy, 0);
      check("inv_ovf",  bus.ovf,  0);

`ifdef JT51_CHWR_COALESCE_EN
      cen = 1'b0;
      put(8'h30, 8'h10);
      put(8'h31, 8'h20);
      put(8'h31, 8'h24);
      cen = 1'b1;
      n = 0;
      while (!(bus.up_kf_ch && bus.cur_ch == 3'd1) && n < 20) begin
         tick();
         n++;
      end
      check("coal_found", n < 20, 1);
      check("coal_dout",  bus.dout, 8'h24);
      tick();
      check("coal_idle",  bus.busy, 0);
`endif

      // Randomized traffic: sparse then dense, dense phase on few keys
      for (int i = 0; i < 3000; i++) begin
         cen = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, (i < 1500) ? 5 : 1) == 0) begin
            bus.wr  = 1'b1;
            bus.din = 8'($urandom);
            if ($urandom_range(0, 9) == 0)
               bus.addr = 8'($urandom);
            else if (i < 1500)
               bus.addr = 8'h20 + 8'($urandom_range(0, 31));
            else
               bus.addr = 8'h28 + 8'($urandom_range(0, 3));
         end
         if ($urandom_range(0, 15) == 0) bus.ovf_clr = 1'b1;
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/jt51_ch_wr_sched.md
Name: jt51_ch_wr_sched

Overview:
- Channel-register write scheduler; sits directly upstream of the per-channel register ring.
- Accepts CPU writes to the per-channel register range 0x20–0x3F and queues them in a small FIFO.
- Releases each write only when its target channel's slot is at the ring input. At that point it drives the matching up_*_ch strobes and the data byte for one cen cycle.

Parameters:
- DEPTH, 4: FIFO entries; power of two, 2..16.
- CH_OFFSET, 0: value added (mod 8) to cur_ch to align the slot counter with ring stage 0.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cen  in  1  clock enable; the slot advances only on cen
- wr  in  1  write strobe, one clk cycle per write, independent of cen
- addr  in  8  register address
- din  in  8  register data
- ovf_clr  in  1  clears ovf
- dout  out  8  data byte for the ring; feeds the ring's din
- up_rl_ch, up_fb_ch, up_con_ch, up_kc_ch, up_kf_ch, up_ams_ch, up_pms_ch  out  1 each  field update strobes
- cur_ch  out  3  channel currently at ring input
- busy  out  1  FIFO not empty
- full  out  1  FIFO full
- ovf  out  1  sticky write-dropped flag

Behaviour:
- Reset (async, rst_n=0):
  - FIFO empty, cur_ch=CH_OFFSET, ovf=0.
  - All strobes 0, dout=0, busy=0, full=0.
- Slot counter:
  - Internal cnt increments mod 8 on every clk with cen=1; 7 wraps to 0.
  - cur_ch = cnt+CH_OFFSET mod 8.
- Address decode at push, using addr[7:3]; channel = addr[2:0]:
  - 0x20–0x27 → group RFC: rl, fb, con.
  - 0x28–0x2F → group KC.
  - 0x30–0x37 → group KF.
  - 0x38–0x3F → group PA: ams, pms.
  - Any other address is not enqueued, has no effect and never sets ovf.
- Push:
  - wr=1 with a valid address and not full stores {group[1:0], ch[2:0], din} at the tail.
  - wr=1 while full, with no pop in the same cycle, drops the write and sets ovf=1.
  - If full and a pop occurs in the same cycle, the push is accepted.
- Head match:
  - busy=1 and head.ch==cur_ch.
  - While matched, strobes are a combinational decode of head.group; all others are 0.
  - dout = head.data while busy, else 0. Strobes and dout are stable across non-cen cycles.
- Pop:
  - On a clk with cen=1 and head match, the head is removed.
  - The next entry becomes eligible from the following clk.
  - Back-to-back entries for the same channel wait a full ring turn (8 cen).
- Latency: from push into an empty FIFO until pop, 1 to 8 cen cycles.
- Ordering:
  - Strict FIFO; a later write to a different channel never overtakes.
  - The head blocks until its slot comes around.
- ovf:
  - Set on drop; cleared by ovf_clr=1.
  - If a drop and ovf_clr occur in the same cycle, set wins.
- full = count==DEPTH; busy = count!=0; both registered from the count.
- cen=0 indefinitely: the FIFO still accepts pushes, and nothing pops.

Optional Feature:
- Macro: JT51_CHWR_COALESCE_EN.
- Defined:
  - A push whose {group,ch} equals a queued entry other than the head overwrites that entry's data in place.
  - No new entry is added, and the push succeeds even when full (no ovf).
  - A match on the head entry pushes normally, since the head may be popping.
- Undefined: every valid push takes a new entry.

Test Plan:
- Reset: assert rst_n=0 mid-queue with 3 entries → immediately busy=0, all strobes 0, dout=0, cur_ch=0, ovf=0.
- Single write: cen every clk, cnt=2, write addr 0x2D din 0x45 → KC strobe plus dout=0x45 only when cur_ch=5 (3 cen later); pop; busy=0.
- RFC/PA groups: write 0x20=0xC7 and 0x38=0x31 → up_rl/up_fb/up_con together at ch0, then up_ams/up_pms at ch0 exactly 8 cen later; no other strobes.
- Overflow: cen=0, DEPTH=4, five valid writes → full=1, ovf=1, four entries drain in order once cen resumes; ovf_clr → ovf=0.
- Invalid address: write 0x08 and 0x40 → busy stays 0, no strobe, ovf stays 0.
- Coalesce (macro defined): cen=0, writes 0x30=0x10, 0x31=0x20, 0x31=0x24 → two entries; ch1 KF strobe carries dout=0x24.
